// File: rtl/servant_bram_pkg.sv
// Shared types and constants for the servant Wishbone-to-BRAM bridge.
// Byte-lane BRAM geometry, FSM state encoding and the BRAM address helper.
package servant_bram_pkg;

  localparam int unsigned BRAM_AW = 9;
  localparam int unsigned BRAM_DW = 8;
  localparam logic [1:0] RATIO_X8 = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    RD_DRAIN,
    ACK
  } state_t;

  function automatic logic [BRAM_AW-1:0] byte_addr(
    input logic [6:0] wadr,
    input logic [1:0] lane
  );
    return {wadr, lane};
  endfunction

endpackage

// File: rtl/servant_bram_bridge_if.sv
// Wishbone classic bundle between the servant arbiter and the BRAM bridge.
// Ports: adr/dat/sel/we/cyc from master, rdt/ack from slave.
interface servant_bram_bridge_if #(
  parameter int unsigned AW = 9
);

  logic [AW-1:2] adr;
  logic [31:0]   dat;
  logic [3:0]    sel;
  logic          we;
  logic          cyc;
  logic [31:0]   rdt;
  logic          ack;

  modport master (
    output adr, dat, sel, we, cyc,
    input  rdt, ack
  );

  modport slave (
    input  adr, dat, sel, we, cyc,
    output rdt, ack
  );

endinterface

// File: rtl/servant_bram_rd_pipe.sv
// Delay line tagging each issued read beat with its lane until BRAM data is valid.
// Ports: clk/rst, flush, in_valid/in_lane, out_valid/out_lane after DEPTH cycles.
module servant_bram_rd_pipe #(
  parameter int unsigned DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  input  logic [1:0] in_lane,
  output logic       out_valid,
  output logic [1:0] out_lane
);

  logic [DEPTH-1:0] v_q;
  logic [1:0]       l_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      v_q <= '0;
    end else begin
      v_q[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        v_q[i] <= v_q[i-1];
      end
    end
  end

  // Lane tags are only meaningful alongside a set valid bit.
  always_ff @(posedge clk) begin
    l_q[0] <= in_lane;
    for (int i = 1; i < DEPTH; i++) begin
      l_q[i] <= l_q[i-1];
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_lane  = l_q[DEPTH-1];

endmodule

// File: rtl/servant_bram_bridge.sv
// Serialises 32-bit Wishbone accesses into four byte beats on 512x8 BRAM banks.
// Ports: i_wb_clk/i_wb_rst, wb (slave), o_bram_* commands, i_bram_dout per bank.
module servant_bram_bridge
  import servant_bram_pkg::*;
#(
  parameter int unsigned N_BANKS    = 1,
  parameter int unsigned aw         = $clog2(512 * N_BANKS),
  parameter int unsigned RD_LAT     = 1,
  parameter logic [1:0]  BRAM_RATIO = RATIO_X8
) (
  input  logic                    i_wb_clk,
  input  logic                    i_wb_rst,
  servant_bram_bridge_if.slave    wb,
  output logic [1:0]              o_bram_ratio,
  output logic [N_BANKS-1:0]      o_bram_wen,
  output logic [N_BANKS-1:0]      o_bram_wclken,
  output logic [BRAM_AW-1:0]      o_bram_waddr,
  output logic [BRAM_DW-1:0]      o_bram_din,
  output logic [N_BANKS-1:0]      o_bram_ren,
  output logic [N_BANKS-1:0]      o_bram_rclken,
  output logic [BRAM_AW-1:0]      o_bram_raddr,
  input  logic [8*N_BANKS-1:0]    i_bram_dout
);

  state_t            state;
  logic [1:0]        lane;
  logic [aw-1:2]     adr_q;
  logic [31:0]       dat_q;
  logic [3:0]        sel_q;
  logic              we_q;
  logic              ack_q;
  logic [31:0]       rdt_q;
  logic              rd_beat;
  logic [1:0]        beat_lane;

  logic [aw-3:0]     bank_idx;
  logic [N_BANKS-1:0] bank_oh;
  logic [BRAM_AW-1:0] baddr;
  logic              abort;
  logic              cap_v;
  logic [1:0]        cap_lane;
  logic              last_cap;
  logic [7:0]        rd_byte;

  // Word address >> 7 is byte address >> 9, i.e. the bank number.
  // Out-of-range banks shift the one-hot off the end: no bank enabled.
  assign bank_idx = adr_q >> 7;
  assign bank_oh  = N_BANKS'(1) << bank_idx;
  assign baddr    = byte_addr(adr_q[8:2], lane);

  assign abort    = ((state == XFER) || (state == RD_DRAIN)) && !wb.cyc;
  assign last_cap = cap_v && (cap_lane == 2'd3);

  assign o_bram_ratio = BRAM_RATIO;
  assign wb.rdt       = rdt_q;
  assign wb.ack       = ack_q;

  always_comb begin
    rd_byte = '0;
    for (int unsigned b = 0; b < N_BANKS; b++) begin
      if (bank_oh[b]) begin
        rd_byte = i_bram_dout[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state         <= IDLE;
      lane          <= '0;
      adr_q         <= '0;
      dat_q         <= '0;
      sel_q         <= '0;
      we_q          <= 1'b0;
      ack_q         <= 1'b0;
      rd_beat       <= 1'b0;
      beat_lane     <= '0;
      o_bram_wen    <= '0;
      o_bram_wclken <= '0;
      o_bram_ren    <= '0;
      o_bram_rclken <= '0;
      o_bram_waddr  <= '0;
      o_bram_raddr  <= '0;
      o_bram_din    <= '0;
    end else begin
      o_bram_wen    <= '0;
      o_bram_wclken <= '0;
      o_bram_ren    <= '0;
      o_bram_rclken <= '0;
      rd_beat       <= 1'b0;
      unique case (state)
        IDLE: begin
          ack_q <= 1'b0;
          if (wb.cyc && !ack_q) begin
            adr_q <= wb.adr;
            dat_q <= wb.dat;
            sel_q <= wb.sel;
            we_q  <= wb.we;
            lane  <= '0;
            state <= XFER;
          end
        end
        XFER: begin
          if (!wb.cyc) begin
            state <= IDLE;
          end else begin
            beat_lane <= lane;
            if (we_q) begin
              o_bram_wclken <= bank_oh;
              o_bram_wen    <= sel_q[lane] ? bank_oh : '0;
              o_bram_waddr  <= baddr;
              o_bram_din    <= dat_q[{lane, 3'b000} +: 8];
            end else begin
              o_bram_ren    <= bank_oh;
              o_bram_rclken <= bank_oh;
              o_bram_raddr  <= baddr;
              rd_beat       <= 1'b1;
            end
            lane <= lane + 2'd1;
            if (lane == 2'd3) begin
              state <= we_q ? ACK : RD_DRAIN;
            end
          end
        end
        RD_DRAIN: begin
          if (!wb.cyc) begin
            state <= IDLE;
          end else if (last_cap) begin
            ack_q <= 1'b1;
            state <= ACK;
          end
        end
        ACK: begin
          // Writes enter with ack low and raise it here;
          // reads enter with ack already raised on the last capture.
          if (!ack_q) begin
            ack_q <= 1'b1;
          end else begin
            ack_q <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      rdt_q <= '0;
    end else if (cap_v && !abort) begin
      rdt_q[{cap_lane, 3'b000} +: 8] <= rd_byte;
    end
  end

  servant_bram_rd_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_pipe (
    .clk       (i_wb_clk),
    .rst       (i_wb_rst),
    .flush     (abort),
    .in_valid  (rd_beat),
    .in_lane   (beat_lane),
    .out_valid (cap_v),
    .out_lane  (cap_lane)
  );

endmodule

// File: tb/tb_servant_bram_bridge.sv
// Directed bench: two bridges (RD_LAT 1 and 2, two banks) on one stimulus.
// Ports: none; drives both Wishbone interfaces and models the BRAM banks.
module tb_servant_bram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:2]  adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cycA, cycB;

  int errors = 0;
  int checks = 0;
  int tA, tB;

  logic [1:0] wenA, wclkA, renA, rclkA;
  logic [1:0] wenB, wclkB, renB, rclkB;
  logic [8:0] waddrA, raddrA, waddrB, raddrB;
  logic [7:0] dinA, dinB;
  logic [1:0] ratioA, ratioB;
  logic [15:0] doutA, doutB;

  logic [7:0] memA [1024];
  logic [7:0] memB [1024];
  logic [7:0] q0A [2];
  logic [7:0] q0B [2];
  logic [7:0] q1B [2];

  logic [1:0] lwen  [16];
  logic [1:0] lwclk [16];
  logic [1:0] lren  [16];
  logic [8:0] lwa   [16];
  logic [8:0] lra   [16];
  logic [7:0] ldin  [16];

  always #5 clk = ~clk;

  servant_bram_bridge_if #(.AW(10)) wbA ();
  servant_bram_bridge_if #(.AW(10)) wbB ();

  assign wbA.adr = adr;
  assign wbA.dat = dat;
  assign wbA.sel = sel;
  assign wbA.we  = we;
  assign wbA.cyc = cycA;
  assign wbB.adr = adr;
  assign wbB.dat = dat;
  assign wbB.sel = sel;
  assign wbB.we  = we;
  assign wbB.cyc = cycB;

  servant_bram_bridge #(
    .N_BANKS (2),
    .RD_LAT  (1)
  ) dutA (
    .i_wb_clk      (clk),
    .i_wb_rst      (rst),
    .wb            (wbA),
    .o_bram_ratio  (ratioA),
    .o_bram_wen    (wenA),
    .o_bram_wclken (wclkA),
    .o_bram_waddr  (waddrA),
    .o_bram_din    (dinA),
    .o_bram_ren    (renA),
    .o_bram_rclken (rclkA),
    .o_bram_raddr  (raddrA),
    .i_bram_dout   (doutA)
  );

  servant_bram_bridge #(
    .N_BANKS (2),
    .RD_LAT  (2)
  ) dutB (
    .i_wb_clk      (clk),
    .i_wb_rst      (rst),
    .wb            (wbB),
    .o_bram_ratio  (ratioB),
    .o_bram_wen    (wenB),
    .o_bram_wclken (wclkB),
    .o_bram_waddr  (waddrB),
    .o_bram_din    (dinB),
    .o_bram_ren    (renB),
    .o_bram_rclken (rclkB),
    .o_bram_raddr  (raddrB),
    .i_bram_dout   (doutB)
  );

  // BRAM models: one-cycle primitive, plus an output register for B.
  always @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (wclkA[b] && wenA[b]) memA[b*512 + int'(waddrA)] <= dinA;
      if (wclkB[b] && wenB[b]) memB[b*512 + int'(waddrB)] <= dinB;
      if (renA[b] && rclkA[b]) q0A[b] <= memA[b*512 + int'(raddrA)];
      if (renB[b] && rclkB[b]) q0B[b] <= memB[b*512 + int'(raddrB)];
      q1B[b] <= q0B[b];
    end
  end

  assign doutA = {q0A[1], q0A[0]};
  assign doutB = {q1B[1], q1B[0]};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Index i is the sample taken #1 after edge E(i); E0 latches the request.
  task automatic run(input logic w, input logic [9:0] badr,
                     input logic [31:0] d, input logic [3:0] s,
                     input int drop_at, input int rst_at);
    adr  = badr[9:2];
    dat  = d;
    sel  = s;
    we   = w;
    cycA = 1'b1;
    cycB = 1'b1;
    tA   = -1;
    tB   = -1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      lwen[i]  = wenA;
      lwclk[i] = wclkA;
      lren[i]  = renA | rclkA;
      lwa[i]   = waddrA;
      lra[i]   = raddrA;
      ldin[i]  = dinA;
      if (wbA.ack && tA < 0) begin
        tA   = i;
        cycA = 1'b0;
      end
      if (wbB.ack && tB < 0) begin
        tB   = i;
        cycB = 1'b0;
      end
      if (i == drop_at || i == rst_at) begin
        cycA = 1'b0;
        cycB = 1'b0;
      end
      rst = (i == rst_at);
      if (tA >= 0 && tB >= 0) break;
    end
    rst  = 1'b0;
    cycA = 1'b0;
    cycB = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      memA[i] = '0;
      memB[i] = '0;
    end
    rst  = 1'b1;
    cycA = 1'b0;
    cycB = 1'b0;
    adr  = '0;
    dat  = '0;
    sel  = '0;
    we   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ackA", 32'(wbA.ack), 32'd0);
    chk("rst_rdtA", wbA.rdt, 32'h0);
    chk("rst_enA", 32'(wenA | wclkA | renA | rclkA), 32'd0);
    chk("rst_addrA", 32'({waddrA, raddrA, dinA}), 32'd0);
    chk("rst_rdtB", wbB.rdt, 32'h0);
    chk("ratio", 32'({ratioA, ratioB}), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset while lane 2 is on the BRAM port.
    run(1'b1, 10'h080, 32'h55667788, 4'hF, -1, 3);
    chk("rst_mid_lane2", 32'(lwen[3]), 32'd1);
    chk("rst_mid_en", 32'(lwen[4] | lwclk[4] | lren[4]), 32'd0);
    chk("rst_mid_noackA", 32'(tA), 32'hFFFF_FFFF);
    chk("rst_mid_noackB", 32'(tB), 32'hFFFF_FFFF);

    // Full-word write.
    run(1'b1, 10'h010, 32'hA1B2C3D4, 4'hF, -1, -1);
    chk("wr_ackA_t", 32'(tA), 32'd5);
    chk("wr_ackB_t", 32'(tB), 32'd5);
    chk("wr_din", {ldin[4], ldin[3], ldin[2], ldin[1]}, 32'hA1B2C3D4);
    chk("wr_waddr0", 32'(lwa[1]), 32'h010);
    chk("wr_waddr3", 32'(lwa[4]), 32'h013);
    chk("wr_wen", 32'({lwen[4], lwen[3], lwen[2], lwen[1]}), 32'h55);
    chk("wr_idle_en", 32'(lwen[5] | lwclk[5]), 32'd0);

    // Read back at both latencies.
    run(1'b0, 10'h010, 32'h0, 4'h0, -1, -1);
    chk("rd_ackA_t", 32'(tA), 32'd6);
    chk("rd_ackB_t", 32'(tB), 32'd7);
    chk("rd_rdtA", wbA.rdt, 32'hA1B2C3D4);
    chk("rd_rdtB", wbB.rdt, 32'hA1B2C3D4);
    chk("rd_raddr", 32'({lra[1], lra[4]}), {14'd0, 9'h010, 9'h013});

    // Partial write, lanes 0 and 2.
    run(1'b1, 10'h010, 32'h11223344, 4'b0101, -1, -1);
    chk("pw_wen", 32'({lwen[4], lwen[3], lwen[2], lwen[1]}), 32'h11);
    chk("pw_wclk", 32'({lwclk[4], lwclk[3], lwclk[2], lwclk[1]}), 32'h55);
    chk("pw_din", 32'({ldin[3], ldin[1]}), 32'h2244);
    run(1'b0, 10'h010, 32'h0, 4'h0, -1, -1);
    chk("pw_rdtA", wbA.rdt, 32'hA122C344);
    chk("pw_rdtB", wbB.rdt, 32'hA122C344);

    // Bank 1 write; rdt holds across it.
    run(1'b1, 10'h204, 32'hDEADBEEF, 4'hF, -1, -1);
    chk("b1_wen", 32'({lwen[4], lwen[3], lwen[2], lwen[1]}), 32'hAA);
    chk("b1_wclk", 32'({lwclk[4], lwclk[3], lwclk[2], lwclk[1]}), 32'hAA);
    chk("b1_waddr", 32'({lwa[1], lwa[4]}), {14'd0, 9'h004, 9'h007});
    chk("b1_rdt_hold", wbA.rdt, 32'hA122C344);
    run(1'b0, 10'h004, 32'h0, 4'h0, -1, -1);
    chk("b0_rdtA", wbA.rdt, 32'h0);
    chk("b0_rdtB", wbB.rdt, 32'h0);
    run(1'b0, 10'h204, 32'h0, 4'h0, -1, -1);
    chk("b1_rdtA", wbA.rdt, 32'hDEADBEEF);
    chk("b1_rdtB", wbB.rdt, 32'hDEADBEEF);

    // Abort a write after lane 1.
    run(1'b1, 10'h020, 32'h99887766, 4'hF, 2, -1);
    chk("ab_noackA", 32'(tA), 32'hFFFF_FFFF);
    chk("ab_noackB", 32'(tB), 32'hFFFF_FFFF);
    chk("ab_lane1", 32'(lwen[2]), 32'd1);
    chk("ab_en_off", 32'(lwen[3] | lwclk[3]), 32'd0);
    run(1'b0, 10'h020, 32'h0, 4'h0, -1, -1);
    chk("ab_rdtA", wbA.rdt, 32'h00007766);
    chk("ab_rdtB", wbB.rdt, 32'h00007766);

    // Word interrupted by reset kept lanes 0..2.
    run(1'b0, 10'h080, 32'h0, 4'h0, -1, -1);
    chk("rst_word_A", wbA.rdt, 32'h00667788);
    chk("rst_word_B", wbB.rdt, 32'h00667788);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
